alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Parameters
REQ-001 DATA_W, default 8: operand width; result width is 2*DATA_W.
REQ-002 DEPTH, default 4: command FIFO entries; power of 2, at least 2.
REQ-003 TIMEOUT, default 64: maximum cycles spent waiting for alu_done, at least 2.

Interface
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1; cmd_ready  output  1: command handshake.
REQ-007 cmd_a, cmd_b  input  DATA_W: operands. cmd_op  input  3: opcode.
REQ-008 alu_a, alu_b  output  DATA_W; alu_op  output  3; alu_start  output  1: drive to the ALU.
REQ-009 alu_reset_n  output  1: active-low reset to the ALU.
REQ-010 alu_done  input  1; alu_result  input  2*DATA_W: ALU completion and result.
REQ-011 rsp_valid  output  1; rsp_ready  input  1: response handshake.
REQ-012 rsp_result  output  2*DATA_W; rsp_op  output  3; rsp_timeout  output  1: response payload.
REQ-013 cmd_count  output  clog2(DEPTH+1): FIFO occupancy. busy  output  1: FSM not in IDLE.

Function
REQ-014 Opcodes:
- 000 no_op; 001 add; 010 and; 011 xor; 100 mul; 111 rst_op.
- 101 and 110 are illegal.
REQ-015 Command FIFO:
- cmd_ready = (cmd_count < DEPTH).
- A push occurs when cmd_valid && cmd_ready.
- When full, cmd_ready is 0; a pop in the same cycle does not enable a push.
- Pointers wrap modulo DEPTH.
REQ-016 The FSM has states IDLE, ISSUE, WAIT, NOP, RSTA, RESP.
REQ-017 IDLE pops the FIFO head into registers when the FIFO is non-empty. Next state by opcode:
- no_op -> NOP
- rst_op -> RSTA
- illegal -> IDLE (command dropped, no ALU activity, no response)
- otherwise -> ISSUE
REQ-018 Latency: a command pushed in cycle N is popped in N+1 at the earliest; alu_start is first high in N+2.
REQ-019 ISSUE/WAIT:
- alu_start = 1; alu_a, alu_b, alu_op hold the registered command.
- A 32-bit-safe timeout counter loads 0 on entry and increments each cycle.
REQ-020 In WAIT, alu_done = 1 sampled in a cycle:
- captures alu_result;
- sets rsp_timeout = 0;
- moves to RESP;
- alu_start is 0 in the next cycle.
REQ-021 If the counter reaches TIMEOUT without alu_done, the FSM moves to RESP with rsp_result = 0 and rsp_timeout = 1, and alu_start drops.
REQ-022 NOP drives alu_start = 1 for exactly one cycle, then returns to IDLE; no response is produced.
REQ-023 RSTA drives alu_reset_n = 0 and alu_start = 0 for exactly 2 cycles, then returns to IDLE; no response is produced.
REQ-024 RESP:
- rsp_valid = 1 with stable payload until rsp_ready = 1.
- Returns to IDLE after the handshake cycle.
- The FIFO continues to accept commands while in RESP.
REQ-025 alu_done arriving outside WAIT is ignored.
REQ-026 alu_reset_n = 1 except in RSTA and during reset.

Reset
REQ-027 While reset = 1, outputs are:
- cmd_count = 0, cmd_ready = 0
- rsp_valid = 0, rsp_result = 0, rsp_op = 0, rsp_timeout = 0
- alu_start = 0, alu_a = 0, alu_b = 0, alu_op = 0
- alu_reset_n = 0, busy = 0
REQ-028 Reset asserted mid-operation:
- flushes the FIFO;
- abandons any in-flight command without producing a response;
- places the FSM in IDLE on the first cycle after reset deasserts;
- cmd_ready = 1 on that cycle.

Verification
REQ-029 Push add a=8'h05 b=8'h03; ALU asserts done 3 cycles after start with result 8 -> rsp_result = 16'h0008, rsp_op = 001, rsp_timeout = 0; alu_start high for 4 cycles.
REQ-030 Push mul 8'hFF x 8'hFF with rsp_ready held 0 for 10 cycles -> rsp_valid holds 16'hFE01 stable; FIFO fills to DEPTH and cmd_ready = 0; draining resumes in order.
REQ-031 Push xor with alu_done never asserted, TIMEOUT = 64 -> after 64 WAIT cycles, rsp_timeout = 1 and rsp_result = 0; alu_start = 0 thereafter.
REQ-032 Push no_op, rst_op, and add -> alu_start pulses 1 cycle; then alu_reset_n = 0 for 2 cycles; then exactly one response (add) is produced.
REQ-033 Push illegal op 101 followed by and 8'hF0 & 8'h3C -> no ALU activity for the illegal op; single response 16'h0030.
REQ-034 Assert reset during WAIT with 3 commands queued -> no response, cmd_count = 0; the next command after reset completes normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time and returns results with timeout
module alu_cmd_sequencer #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [DATA_W-1:0]          cmd_a,
   input  logic [DATA_W-1:0]          cmd_b,
   input  logic [2:0]                 cmd_op,
   output logic [DATA_W-1:0]          alu_a,
   output logic [DATA_W-1:0]          alu_b,
   output logic [2:0]                 alu_op,
   output logic                       alu_start,
   output logic                       alu_reset_n,
   input  logic                       alu_done,
   input  logic [2*DATA_W-1:0]        alu_result,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [2*DATA_W-1:0]        rsp_result,
   output logic [2:0]                 rsp_op,
   output logic                       rsp_timeout,
   output logic [$clog2(DEPTH+1)-1:0] cmd_count,
   output logic                       busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NOP, RSTA, RESP} state_t;
   state_t            state;
   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] mem_b [DEPTH];
   logic [2:0]        mem_op [DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [31:0]       tmr;
   logic              push, pop, illegal;
   logic [2:0]        head_op;
   assign cmd_ready   = !reset && (cmd_count < CW'(DEPTH));
   assign push        = cmd_valid && cmd_ready;
   assign pop         = (state == IDLE) && (cmd_count != '0);
   assign head_op     = mem_op[rp];
   assign illegal     = (head_op == 3'b101) || (head_op == 3'b110);
   assign alu_reset_n = !reset && (state != RSTA);
   assign busy        = !reset && (state != IDLE);
   // command storage, written on every accepted push
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wp]  <= cmd_a;
         mem_b[wp]  <= cmd_b;
         mem_op[wp] <= cmd_op;
      end
   end
   // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         wp        <= '0;
         rp        <= '0;
         cmd_count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cmd_count <= cmd_count + CW'(push) - CW'(pop);
      end
   end
   // command sequencing FSM with registered ALU drive and response payload
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         tmr         <= '0;
         alu_start   <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_op      <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (pop && !illegal) begin
               alu_a     <= mem_a[rp];
               alu_b     <= mem_b[rp];
               alu_op    <= head_op;
               alu_start <= head_op != 3'b111;
               tmr       <= '0;
               state     <= head_op == 3'b000 ? NOP : head_op == 3'b111 ? RSTA : ISSUE;
            end
            ISSUE: begin
               tmr   <= '0;
               state <= WAIT;
            end
            WAIT: if (alu_done || tmr == 32'(TIMEOUT - 1)) begin
               rsp_result  <= alu_done ? alu_result : '0;
               rsp_timeout <= !alu_done;
               rsp_op      <= alu_op;
               rsp_valid   <= 1'b1;
               alu_start   <= 1'b0;
               state       <= RESP;
            end else tmr <= tmr + 1'b1;
            NOP: begin
               alu_start <= 1'b0;
               state     <= IDLE;
            end
            RSTA: if (tmr == 32'd1) state <= IDLE;
            else tmr <= tmr + 1'b1;
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized scoreboard bench with a behavioural ALU for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int TO = 64;
   typedef struct {logic [DW-1:0] a; logic [DW-1:0] b; logic [2:0] op; int len;} iss_t;
   typedef struct {logic [2*DW-1:0] res; logic [2:0] op; logic to;} rsp_t;
   logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready;
   logic [DW-1:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b;
   logic [2:0] cmd_op = 0, alu_op, rsp_op;
   logic alu_start, alu_reset_n, alu_done = 0, rsp_valid, rsp_ready = 0, rsp_timeout, busy;
   logic [2*DW-1:0] alu_result = 0, rsp_result;
   logic [2:0] cmd_count;
   int checks = 0, errors = 0, nrsp = 0, rst_seen = 0, lat = 3, rdy_mode = 1;
   iss_t iss_q[$];
   rsp_t exp_q[$];

   alu_cmd_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_reset_n(alu_reset_n), .alu_done(alu_done), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_op(rsp_op), .rsp_timeout(rsp_timeout), .cmd_count(cmd_count), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [2*DW-1:0] ref_res(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op);
      logic [2*DW-1:0] x, y;
      x = {{DW{1'b0}}, a};
      y = {{DW{1'b0}}, b};
      case (op)
         3'd1: return x + y;
         3'd2: return x & y;
         3'd3: return x ^ y;
         3'd4: return x * y;
         default: return '0;
      endcase
   endfunction

   // expected ALU activity and responses, derived from each accepted command
   task automatic model_push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op);
      if (op == 3'd0) iss_q.push_back('{a, b, op, 1});
      else if (op >= 3'd1 && op <= 3'd4) begin
         iss_q.push_back('{a, b, op, lat < 0 ? TO + 1 : lat + 1});
         exp_q.push_back('{lat < 0 ? '0 : ref_res(a, b, op), op, lat < 0});
      end
   endtask

   task automatic push_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op);
      int n = 0;
      cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op;
      while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL push_accept: cmd_ready stayed %b for %0d cycles, required 1", cmd_ready, n);
      end else model_push(a, b, op);
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || iss_q.size() != 0 || busy || cmd_count != 0) && n < budget) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain: %0d responses and %0d issues outstanding, busy=%b count=%0d, required none", exp_q.size(), iss_q.size(), busy, cmd_count);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1; cmd_valid = 1;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_count, cmd_ready} !== 4'b0) begin errors++; $display("FAIL reset_fifo: count=%0d ready=%b required 0/0", cmd_count, cmd_ready); end
      checks++;
      if ({rsp_valid, rsp_result, rsp_op, rsp_timeout} !== 21'b0) begin errors++; $display("FAIL reset_rsp: valid=%b result=%h op=%0d to=%b required all 0", rsp_valid, rsp_result, rsp_op, rsp_timeout); end
      checks++;
      if ({alu_start, alu_a, alu_b, alu_op} !== 20'b0) begin errors++; $display("FAIL reset_alu: start=%b a=%h b=%h op=%0d required all 0", alu_start, alu_a, alu_b, alu_op); end
      checks++;
      if ({alu_reset_n, busy} !== 2'b0) begin errors++; $display("FAIL reset_ctrl: alu_reset_n=%b busy=%b required 0/0", alu_reset_n, busy); end
      cmd_valid = 0;
      iss_q.delete(); exp_q.delete();
      reset = 0;
      #1;
      checks++;
      if ({cmd_ready, busy, alu_reset_n, cmd_count} !== {3'b101, 3'b0}) begin
         errors++;
         $display("FAIL post_reset: ready=%b busy=%b alu_reset_n=%b count=%0d required 1/0/1/0", cmd_ready, busy, alu_reset_n, cmd_count);
      end
   endtask

   // behavioural ALU: completes lat cycles after start rises, and checks issued operands and start length
   initial begin
      int k = 0, len = 0;
      bit prev = 0, have = 0;
      iss_t cur;
      forever begin
         @(negedge clk); #1;
         if (reset) begin prev = 0; have = 0; alu_done = 0; continue; end
         if (alu_start && !prev) begin
            k = 0; len = 1;
            checks++;
            if (iss_q.size() == 0) begin
               errors++; have = 0;
               $display("FAIL start_unexpected: alu_start rose with op %0d, required no ALU activity", alu_op);
            end else begin
               cur = iss_q.pop_front(); have = 1;
               if ({alu_a, alu_b, alu_op} !== {cur.a, cur.b, cur.op}) begin
                  errors++;
                  $display("FAIL alu_operands: got a=%h b=%h op=%0d required a=%h b=%h op=%0d", alu_a, alu_b, alu_op, cur.a, cur.b, cur.op);
               end
            end
         end else if (alu_start) begin k++; len++; end
         else if (prev && have) begin
            checks++; have = 0;
            if (len != cur.len) begin errors++; $display("FAIL start_len: op %0d start high %0d cycles, required %0d", cur.op, len, cur.len); end
         end
         prev = alu_start;
         alu_done = alu_start && lat > 0 && k == lat;
         alu_result = ref_res(alu_a, alu_b, alu_op);
      end
   end

   // alu_reset_n pulse monitor: every low pulse outside reset lasts two cycles
   initial begin
      int lowc = 0;
      forever begin
         @(negedge clk); #1;
         if (reset) lowc = 0;
         else if (!alu_reset_n) lowc++;
         else if (lowc != 0) begin
            checks++; rst_seen++;
            if (lowc != 2) begin errors++; $display("FAIL rsta_len: alu_reset_n low %0d cycles, required 2", lowc); end
            lowc = 0;
         end
      end
   end

   // response scoreboard with payload stability check while stalled
   initial begin
      rsp_t e;
      bit hold = 0;
      logic [2*DW-1:0] pr;
      logic [2:0] po;
      logic pt;
      forever begin
         @(negedge clk); #1;
         if (reset) begin hold = 0; continue; end
         if (rsp_valid) begin
            if (hold) begin
               checks++;
               if ({rsp_result, rsp_op, rsp_timeout} !== {pr, po, pt}) begin
                  errors++;
                  $display("FAIL rsp_stable: got %h/%0d/%b required %h/%0d/%b", rsp_result, rsp_op, rsp_timeout, pr, po, pt);
               end
            end
            if (rsp_ready) begin
               checks++; nrsp++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rsp_unexpected: got %h/%0d/%b required no response", rsp_result, rsp_op, rsp_timeout);
               end else begin
                  e = exp_q.pop_front();
                  if ({rsp_result, rsp_op, rsp_timeout} !== {e.res, e.op, e.to}) begin
                     errors++;
                     $display("FAIL rsp_payload: got %h/%0d/%b required %h/%0d/%b", rsp_result, rsp_op, rsp_timeout, e.res, e.op, e.to);
                  end
               end
            end
            hold = !rsp_ready; pr = rsp_result; po = rsp_op; pt = rsp_timeout;
         end else hold = 0;
      end
   end

   // response-side ready: 0 held low, 1 held high, 2 random
   initial forever begin
      @(negedge clk);
      rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
   end

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_add();
      int n0 = nrsp;
      lat = 3; rdy_mode = 1;
      push_cmd(8'h05, 8'h03, 3'd1);
      wait_idle(100);
      checks++;
      if (nrsp != n0 + 1) begin errors++; $display("FAIL add_count: %0d responses, required 1", nrsp - n0); end
   endtask

   task automatic test_backpressure();
      int n = 0;
      lat = 2; rdy_mode = 0;
      @(negedge clk);
      push_cmd(8'hFF, 8'hFF, 3'd4);
      for (int i = 0; i < DEPTH; i++) push_cmd(DW'($urandom), DW'($urandom), 3'(1 + $urandom_range(0, 3)));
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_result} !== {1'b1, 16'hFE01}) begin errors++; $display("FAIL bp_hold: valid=%b result=%h required 1/fe01", rsp_valid, rsp_result); end
      cmd_valid = 1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 3'd1;
      checks++;
      if ({cmd_count, cmd_ready} !== {3'(DEPTH), 1'b0}) begin errors++; $display("FAIL bp_full: count=%0d ready=%b required %0d/0", cmd_count, cmd_ready, DEPTH); end
      repeat (2) @(negedge clk);
      cmd_valid = 0;
      checks++;
      if (cmd_count !== 3'(DEPTH)) begin errors++; $display("FAIL bp_no_push: count=%0d required %0d", cmd_count, DEPTH); end
      rdy_mode = 1;
      wait_idle(300);
   endtask

   task automatic test_timeout();
      int n0 = nrsp;
      lat = -1; rdy_mode = 1;
      push_cmd(DW'($urandom), DW'($urandom), 3'd3);
      wait_idle(300);
      checks++;
      if (nrsp != n0 + 1 || alu_start !== 1'b0) begin errors++; $display("FAIL timeout_count: %0d responses start=%b, required 1/0", nrsp - n0, alu_start); end
   endtask

   task automatic test_nop_rst();
      int n0 = nrsp, r0 = rst_seen;
      lat = 3; rdy_mode = 1;
      push_cmd(8'h12, 8'h34, 3'd0);
      push_cmd(8'h56, 8'h78, 3'd7);
      push_cmd(8'h9A, 8'h0B, 3'd1);
      wait_idle(100);
      checks++;
      if (nrsp != n0 + 1 || rst_seen != r0 + 1) begin errors++; $display("FAIL nop_rst: %0d responses %0d alu resets, required 1/1", nrsp - n0, rst_seen - r0); end
   endtask

   task automatic test_illegal();
      int n0 = nrsp;
      lat = 2; rdy_mode = 1;
      push_cmd(DW'($urandom), DW'($urandom), 3'd5);
      push_cmd(8'hF0, 8'h3C, 3'd2);
      push_cmd(DW'($urandom), DW'($urandom), 3'd6);
      wait_idle(100);
      checks++;
      if (nrsp != n0 + 1) begin errors++; $display("FAIL illegal_count: %0d responses, required 1", nrsp - n0); end
   endtask

   task automatic test_reset_mid();
      int n0;
      lat = -1; rdy_mode = 1;
      for (int i = 0; i < 4; i++) push_cmd(DW'($urandom), DW'($urandom), 3'd1);
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, cmd_count} !== {1'b1, 3'd3}) begin errors++; $display("FAIL mid_setup: busy=%b count=%0d required 1/3", busy, cmd_count); end
      n0 = nrsp;
      apply_reset();
      lat = 3;
      push_cmd(8'h21, 8'h43, 3'd1);
      wait_idle(100);
      checks++;
      if (nrsp != n0 + 1) begin errors++; $display("FAIL mid_after: %0d responses, required 1", nrsp - n0); end
   endtask

   task automatic test_random();
      rdy_mode = 2;
      for (int b = 0; b < 5; b++) begin
         lat = (b == 2) ? -1 : $urandom_range(1, 6);
         for (int i = 0; i < 8; i++) begin
            push_cmd(DW'($urandom), DW'($urandom), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_idle(2000);
      end
      rdy_mode = 1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_backpressure();
      test_timeout();
      test_nop_rst();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
